alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

- Sequences the single shared 32-bit ALU between two requesters:
  - port 0: main pipeline
  - port 1: auxiliary unit, e.g. CSR/debug address calculation
- Per-port valid/ready request and response handshakes; round-robin arbitration.
- Operands are registered into the ALU and the ALU result is registered back, so no combinational path runs from a requester through the ALU.
- Sits between the requesters and the combinational ALU; drives its A, B and function inputs and samples its output.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- FUN_W, 4, ALU function code width

Ports:
- CLK  in  1  rising-edge clock, single clock domain
- RST_N  in  1  reset, asynchronous assert, active-low
- req_valid0 / req_valid1  in  1  request valid, port 0 / port 1
- req_ready0 / req_ready1  out  1  request accepted this cycle (valid & ready)
- req_a0 / req_a1  in  WIDTH  operand A
- req_b0 / req_b1  in  WIDTH  operand B
- req_fun0 / req_fun1  in  FUN_W  ALU function code, forwarded unmodified
- rsp_valid0 / rsp_valid1  out  1  result valid for that port
- rsp_ready0 / rsp_ready1  in  1  requester takes result
- rsp_data0 / rsp_data1  out  WIDTH  result, shared register, qualified by rsp_validN
- alu_a, alu_b  out  WIDTH  to shared ALU, driven from internal operand registers
- alu_fun  out  FUN_W  to shared ALU, from function register
- alu_out  in  WIDTH  combinational ALU result

## Operation
- FSM states: IDLE, EXEC, RESP; one transaction in flight at a time.
- IDLE:
  - If any req_valid is high, the arbiter picks winner w.
  - req_ready_w = 1 combinationally in that cycle; the loser's ready stays 0.
  - At the clock edge: latch req_a_w, req_b_w, req_fun_w into op registers, store w in owner register, go to EXEC.
  - Non-winning requests wait; the requester must hold valid and operands stable until accepted.
- EXEC: alu_a/alu_b/alu_fun reflect the op registers; at the edge, capture alu_out into the result register and go to RESP.
- RESP:
  - rsp_valid_owner = 1; the other rsp_valid stays 0.
  - On rsp_ready_owner = 1: go to IDLE and update the round-robin pointer to prefer the non-owner.
  - Otherwise hold; result and valid stay stable.
- Round-robin: pointer names the preferred port.
  - Both valid → preferred port wins.
  - One valid → that port wins regardless of pointer.
- rsp_data0 and rsp_data1 both show the result register; only the owner's valid is asserted.
- req_ready is always 0 outside IDLE, so no request is accepted during EXEC/RESP.
- Function codes are not checked; undefined codes get whatever the ALU returns (its default is add).

## Timing
- Reset values: state = IDLE, pointer = port 0, owner = 0, operand/function/result registers = 0, all req_ready and rsp_valid = 0, alu_a/alu_b/alu_fun = 0.
- Accept edge T. Result registered at T+1. rsp_valid high from T+1 until the response handshake edge.
- Back-to-back throughput is 3 cycles per operation when rsp_ready is held high:
  - accept at T
  - respond at T+2
  - next accept evaluated in IDLE cycle T+2..T+3
- Simultaneous valid on both ports after reset: port 0 first, then port 1, then port 0.
- A requester dropping valid before acceptance is legal; no state change results.
- RST_N asserted mid-transaction: immediate return to IDLE, in-flight op discarded, all outputs to reset values; no response issued after reset release.
- Width: all arithmetic is inside the ALU; this block only registers WIDTH bits with no extension or truncation.

## Configuration
- ALU_SHARE_FIXED_PRIO_EN:
  - Defined: fixed priority, port 0 always wins when both are valid; pointer register removed.
  - Undefined (default): round-robin as above.

## Structure
- Package alu_share_pkg holds:
  - state enum type (IDLE/EXEC/RESP)
  - localparams for the ALU function codes: ADD=0, SUB=1, OR=2, AND=3, XOR=4, SRL=5, SLL=6, SRA=7, SLT=8, SLTU=9, LUI_COPY=10
  - port-index type
- One sub-module is natural: alu_rr_arb2, the two-input arbiter with pointer update. It contains the ALU_SHARE_FIXED_PRIO_EN switch.
- The ALU itself is instantiated outside this block, at the parent level.

## Test plan
- Port 0 only: a=7, b=5, fun=SUB, rsp_ready=1 → req_ready0 pulses once; rsp_valid0 high 2 cycles after acceptance with rsp_data0=2; rsp_valid1 stays 0.
- Both valid every cycle after reset, port 0 fun=ADD 1+2, port 1 fun=XOR 0xF0^0xFF:
  - responses alternate: port 0 gets 3, then port 1 gets 0x0F, then port 0 again
  - with ALU_SHARE_FIXED_PRIO_EN defined, only port 0 is served
- Backpressure: rsp_ready0=0 for 5 cycles → rsp_valid0 and data held stable; req_ready1 stays 0 despite req_valid1=1; port 1 is accepted in the IDLE cycle after rsp_ready0 rises.
- Reset in EXEC: drop RST_N while operating → all outputs 0 asynchronously; after release no rsp_valid appears without a new request.
- Undefined fun=4'b1111 with a=3, b=4 → rsp_data=7 (ALU default add), passed through unmodified.
- Throughput: 10 port-1 requests with rsp_ready1 held at 1 → exactly 3 cycles between consecutive req_ready1 pulses.

Source files
------------

// File: rtl/alu_share_pkg.sv
// Shared types and constants for the shared-ALU sequencer (alu_share_ctrl).
package alu_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Requester index: 0 = main pipeline, 1 = auxiliary unit
  typedef logic port_t;

  localparam logic [3:0] ADD      = 4'd0;
  localparam logic [3:0] SUB      = 4'd1;
  localparam logic [3:0] OR       = 4'd2;
  localparam logic [3:0] AND      = 4'd3;
  localparam logic [3:0] XOR      = 4'd4;
  localparam logic [3:0] SRL      = 4'd5;
  localparam logic [3:0] SLL      = 4'd6;
  localparam logic [3:0] SRA      = 4'd7;
  localparam logic [3:0] SLT      = 4'd8;
  localparam logic [3:0] SLTU     = 4'd9;
  localparam logic [3:0] LUI_COPY = 4'd10;

  function automatic port_t other_port(input port_t p);
    return ~p;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response handshake bundle between the two requesters and alu_share_ctrl.
// master = requester side, slave = controller side.
interface alu_share_ctrl_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FUN_W = 4
);
  logic             req_valid0, req_valid1;
  logic             req_ready0, req_ready1;
  logic [WIDTH-1:0] req_a0, req_a1;
  logic [WIDTH-1:0] req_b0, req_b1;
  logic [FUN_W-1:0] req_fun0, req_fun1;
  logic             rsp_valid0, rsp_valid1;
  logic             rsp_ready0, rsp_ready1;
  logic [WIDTH-1:0] rsp_data0, rsp_data1;

  modport master (
    output req_valid0, req_valid1, req_a0, req_a1, req_b0, req_b1,
           req_fun0, req_fun1, rsp_ready0, rsp_ready1,
    input  req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_data0, rsp_data1
  );

  modport slave (
    input  req_valid0, req_valid1, req_a0, req_a1, req_b0, req_b1,
           req_fun0, req_fun1, rsp_ready0, rsp_ready1,
    output req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_data0, rsp_data1
  );
endinterface

// File: rtl/alu_rr_arb2.sv
// Two-input arbiter for the shared ALU with a round-robin preference pointer.
// Build option: ALU_SHARE_FIXED_PRIO_EN -> port 0 always wins a tie, no pointer.
module alu_rr_arb2
  import alu_share_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,     // request valids, bit N = port N
  input  logic       en,      // arbitration allowed this cycle
  input  logic       update,  // response of the current owner completed
  input  port_t      owner,   // port that owned the completed transaction
  output logic [1:0] grant,   // one-hot grant, zero when nothing is granted
  output port_t      win,
  output logic       any
);

  port_t pref;

`ifdef ALU_SHARE_FIXED_PRIO_EN
  // Port 0 is always preferred on a tie
  always_comb begin
    pref = 1'b0;
  end
`else
  port_t ptr;

  // After a completed response, prefer the port that was not just served
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (update) begin
      ptr <= other_port(owner);
    end
  end

  // Preference follows the pointer
  always_comb begin
    pref = ptr;
  end
`endif

  // Winner: preferred port on a tie, otherwise the sole requester
  always_comb begin
    win   = 1'b0;
    any   = en & (req[0] | req[1]);
    grant = '0;
    if (req[0] && req[1]) begin
      win = pref;
    end else begin
      win = req[1];
    end
    if (any) begin
      grant = win ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: sequences one shared combinational ALU between the main
// pipeline (port 0) and an auxiliary unit (port 1). Operands and result are
// registered so no combinational path crosses the ALU.
// Build option: ALU_SHARE_FIXED_PRIO_EN (handled in alu_rr_arb2).
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FUN_W = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  alu_share_ctrl_if.slave   bus,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [FUN_W-1:0]  alu_fun,
  input  logic [WIDTH-1:0]  alu_out
);

  state_t           state, state_nxt;
  port_t            owner;
  port_t            win;
  logic [1:0]       req_vec, grant;
  logic             any_grant, arb_en, rsp_done;
  logic [WIDTH-1:0] op_a, op_b, result;
  logic [FUN_W-1:0] op_fun;

  assign req_vec = {bus.req_valid1, bus.req_valid0};
  // Gating with RST_N keeps req_ready low while reset is held
  assign arb_en  = (state == IDLE) & RST_N;

  alu_rr_arb2 u_arb (
    .clk    (CLK),
    .rst_n  (RST_N),
    .req    (req_vec),
    .en     (arb_en),
    .update (rsp_done),
    .owner  (owner),
    .grant  (grant),
    .win    (win),
    .any    (any_grant)
  );

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt      = state;
    rsp_done       = 1'b0;
    bus.req_ready0 = 1'b0;
    bus.req_ready1 = 1'b0;
    bus.rsp_valid0 = 1'b0;
    bus.rsp_valid1 = 1'b0;
    unique case (state)
      IDLE: begin
        bus.req_ready0 = grant[0];
        bus.req_ready1 = grant[1];
        if (any_grant) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid0 = (owner == 1'b0);
        bus.rsp_valid1 = (owner == 1'b1);
        if (owner ? bus.rsp_ready1 : bus.rsp_ready0) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture on acceptance, result capture in EXEC
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      owner  <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      op_fun <= '0;
      result <= '0;
    end else begin
      if (any_grant) begin
        owner  <= win;
        op_a   <= win ? bus.req_a1   : bus.req_a0;
        op_b   <= win ? bus.req_b1   : bus.req_b0;
        op_fun <= win ? bus.req_fun1 : bus.req_fun0;
      end
      if (state == EXEC) begin
        result <= alu_out;
      end
    end
  end

  assign alu_a         = op_a;
  assign alu_b         = op_b;
  assign alu_fun       = op_fun;
  assign bus.rsp_data0 = result;
  assign bus.rsp_data1 = result;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: directed cases plus random traffic,
// with a transaction-level scoreboard and a stand-in ALU at the parent level.
module tb_alu_share_ctrl;
  import alu_share_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned FW = 4;
`ifdef ALU_SHARE_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  alu_a, alu_b, alu_out;
  logic [FW-1:0] alu_fun;
  int unsigned   checks = 0;
  int unsigned   errors = 0;
  int unsigned   cyc = 0;

  alu_share_ctrl_if #(.WIDTH(W), .FUN_W(FW)) bus ();

  alu_share_ctrl #(.WIDTH(W), .FUN_W(FW)) dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .bus     (bus),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_fun (alu_fun),
    .alu_out (alu_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference ALU behaviour; unknown codes add
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] f);
    case (f)
      ADD:      return a + b;
      SUB:      return a - b;
      OR:       return a | b;
      AND:      return a & b;
      XOR:      return a ^ b;
      SRL:      return a >> b[4:0];
      SLL:      return a << b[4:0];
      SRA:      return 32'($signed(a) >>> b[4:0]);
      SLT:      return {31'b0, $signed(a) < $signed(b)};
      SLTU:     return {31'b0, a < b};
      LUI_COPY: return b;
      default:  return a + b;
    endcase
  endfunction

  // Parent-level ALU
  always_comb alu_out = ref_alu(alu_a, alu_b, alu_fun);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur in time (t=%0t)", name, $time);
  endtask

  // ---------------- scoreboard / monitor ----------------
  typedef struct { bit port; logic [W-1:0] data; } exp_t;
  exp_t        exp_q[$];
  bit          resp_port_q[$];
  logic [W-1:0] resp_data_q[$];
  bit          m_busy = 1'b0, m_owner = 1'b0, m_ptr = 1'b0, was_busy, mwin;
  int unsigned m_age = 0;
  logic [1:0]  act_rdy, act_rv, exp_rdy, exp_rv, mv, seen_rdy = '0;
  exp_t        e;

  // Transaction-level model of arbitration, latency and results
  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_ptr = 1'b0; m_age = 0; seen_rdy = '0;
      exp_q.delete();
    end else begin
      act_rdy  = {bus.req_ready1, bus.req_ready0};
      act_rv   = {bus.rsp_valid1, bus.rsp_valid0};
      mv       = {bus.req_valid1, bus.req_valid0};
      was_busy = m_busy;
      mwin     = 1'b0;
      if (was_busy) begin
        m_age++;
        exp_rdy = '0;
        exp_rv  = (m_age >= 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      end else begin
        exp_rv = '0;
        if (mv == 2'b11) mwin = FIXED ? 1'b0 : m_ptr;
        else             mwin = mv[1];
        exp_rdy = (mv == 2'b00) ? 2'b00 : (mwin ? 2'b10 : 2'b01);
      end
      chk("req_ready", 64'(act_rdy), 64'(exp_rdy));
      chk("rsp_valid", 64'(act_rv), 64'(exp_rv));
      seen_rdy = act_rdy;
      if (exp_rv != 2'b00) begin
        if (exp_q.size() == 0) begin
          fail_now("sb_empty");
        end else begin
          chk("rsp_data0", 64'(bus.rsp_data0), 64'(exp_q[0].data));
          chk("rsp_data1", 64'(bus.rsp_data1), 64'(exp_q[0].data));
          if (m_owner ? bus.rsp_ready1 : bus.rsp_ready0) begin
            e = exp_q.pop_front();
            resp_port_q.push_back(e.port);
            resp_data_q.push_back(e.data);
            m_busy = 1'b0;
            m_ptr  = ~m_owner;
          end
        end
      end
      if (!was_busy && exp_rdy != 2'b00) begin
        e.port = mwin;
        e.data = mwin ? ref_alu(bus.req_a1, bus.req_b1, bus.req_fun1)
                      : ref_alu(bus.req_a0, bus.req_b0, bus.req_fun0);
        exp_q.push_back(e);
        m_busy  = 1'b1;
        m_owner = mwin;
        m_age   = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int p, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] f);
    if (p == 0) begin
      bus.req_valid0 = v; bus.req_a0 = a; bus.req_b0 = b; bus.req_fun0 = f;
    end else begin
      bus.req_valid1 = v; bus.req_a1 = a; bus.req_b1 = b; bus.req_fun1 = f;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int p, output int unsigned at, output bit ok);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (p == 0 ? bus.req_ready0 : bus.req_ready1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
    if (!ok) fail_now(p == 0 ? "wait_req_ready0" : "wait_req_ready1");
  endtask

  task automatic wait_rsp(input int p, output int unsigned at, output bit ok);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (p == 0 ? bus.rsp_valid0 : bus.rsp_valid1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
    if (!ok) fail_now(p == 0 ? "wait_rsp_valid0" : "wait_rsp_valid1");
  endtask

  task automatic run_one(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] f, input logic [31:0] expd, input string nm);
    int unsigned t_acc, t_rsp;
    bit ok;
    bus.rsp_ready0 = 1'b1;
    bus.rsp_ready1 = 1'b1;
    set_req(p, 1'b1, a, b, f);
    wait_ready(p, t_acc, ok);
    step();
    set_req(p, 1'b0, '0, '0, '0);
    if (ok) begin
      wait_rsp(p, t_rsp, ok);
      if (ok) begin
        chk({nm, "_latency"}, 64'(t_rsp - t_acc), 64'd2);
        chk({nm, "_data"}, 64'(p == 0 ? bus.rsp_data0 : bus.rsp_data1), 64'(expd));
      end
    end
    repeat (2) step();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int unsigned t, tacc[10];
    int unsigned base;
    bit ok, cur_v;
    bus.rsp_ready0 = 1'b0;
    bus.rsp_ready1 = 1'b0;
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);

    // Reset values
    repeat (2) step();
    chk("rst_handshake", 64'({bus.req_ready1, bus.req_ready0, bus.rsp_valid1, bus.rsp_valid0}), 64'd0);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_alu_fun", 64'(alu_fun), 64'd0);
    chk("rst_rsp_data0", 64'(bus.rsp_data0), 64'd0);
    rst_n = 1'b1;
    repeat (2) step();

    // Port 0 alone, SUB 7-5
    run_one(0, 32'd7, 32'd5, SUB, 32'd2, "p0_sub");
    // Undefined code passes through to the ALU default (add)
    run_one(0, 32'd3, 32'd4, 4'hF, 32'd7, "undef_fun");
    run_one(1, 32'hFFFF_FFF0, 32'd4, SRA, 32'hFFFF_FFFF, "p1_sra");

    // Reset while in EXEC
    bus.rsp_ready0 = 1'b1;
    set_req(0, 1'b1, 32'h1234_5678, 32'h42, SUB);
    wait_ready(0, t, ok);
    step();
    set_req(0, 1'b0, '0, '0, '0);
    chk("exec_alu_a", 64'(alu_a), 64'h1234_5678);
    chk("exec_alu_fun", 64'(alu_fun), 64'(SUB));
    #1 rst_n = 1'b0;
    #1;
    chk("arst_alu_a", 64'(alu_a), 64'd0);
    chk("arst_alu_b", 64'(alu_b), 64'd0);
    chk("arst_alu_fun", 64'(alu_fun), 64'd0);
    chk("arst_rsp_data0", 64'(bus.rsp_data0), 64'd0);
    chk("arst_handshake", 64'({bus.req_ready1, bus.req_ready0, bus.rsp_valid1, bus.rsp_valid0}), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_rsp_valid", 64'({bus.rsp_valid1, bus.rsp_valid0}), 64'd0);
    end

    // Both ports valid continuously from reset
    step();
    base = resp_port_q.size();
    bus.rsp_ready0 = 1'b1;
    bus.rsp_ready1 = 1'b1;
    set_req(0, 1'b1, 32'd1, 32'd2, ADD);
    set_req(1, 1'b1, 32'hF0, 32'hFF, XOR);
    repeat (11) step();
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    repeat (5) step();
    if (resp_port_q.size() < base + 3) begin
      fail_now("both_valid_resp_count");
    end else begin
      chk("both_order0", 64'(resp_port_q[base]),     64'd0);
      chk("both_order1", 64'(resp_port_q[base + 1]), FIXED ? 64'd0 : 64'd1);
      chk("both_order2", 64'(resp_port_q[base + 2]), 64'd0);
      chk("both_data0",  64'(resp_data_q[base]),     64'd3);
      chk("both_data1",  64'(resp_data_q[base + 1]), FIXED ? 64'd3 : 64'h0F);
    end

    // Backpressure on port 0 with port 1 waiting
    bus.rsp_ready0 = 1'b0;
    bus.rsp_ready1 = 1'b1;
    set_req(0, 1'b1, 32'd10, 32'd20, ADD);
    wait_ready(0, t, ok);
    step();
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b1, 32'd9, 32'd4, SUB);
    wait_rsp(0, t, ok);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_rsp_valid0", 64'(bus.rsp_valid0), 64'd1);
      chk("bp_rsp_data0", 64'(bus.rsp_data0), 64'd30);
      chk("bp_req_ready1", 64'(bus.req_ready1), 64'd0);
    end
    step();
    bus.rsp_ready0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_p1_accept", 64'(bus.req_ready1), 64'd1);
    step();
    set_req(1, 1'b0, '0, '0, '0);
    repeat (5) step();

    // Throughput: back-to-back port 1 requests
    bus.rsp_ready1 = 1'b1;
    set_req(1, 1'b1, $urandom, $urandom, 4'($urandom_range(0, 10)));
    for (int k = 0; k < 10; k++) begin
      wait_ready(1, tacc[k], ok);
      if (!ok) break;
      step();
      if (k < 9) set_req(1, 1'b1, $urandom, $urandom, 4'($urandom_range(0, 10)));
      else       set_req(1, 1'b0, '0, '0, '0);
      if (k > 0) chk("throughput_gap", 64'(tacc[k] - tacc[k-1]), 64'd3);
    end
    set_req(1, 1'b0, '0, '0, '0);
    repeat (5) step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step();
      for (int p = 0; p < 2; p++) begin
        cur_v = (p == 0) ? bus.req_valid0 : bus.req_valid1;
        if (!cur_v || seen_rdy[p]) begin
          if ($urandom_range(0, 2) != 0)
            set_req(p, 1'b1, $urandom, $urandom, 4'($urandom_range(0, 15)));
          else
            set_req(p, 1'b0, '0, '0, '0);
        end else if ($urandom_range(0, 7) == 0) begin
          set_req(p, 1'b0, '0, '0, '0);
        end
      end
      bus.rsp_ready0 = ($urandom_range(0, 3) != 0);
      bus.rsp_ready1 = ($urandom_range(0, 3) != 0);
    end

    // Drain
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    bus.rsp_ready0 = 1'b1;
    bus.rsp_ready1 = 1'b1;
    for (int i = 0; i < 20 && m_busy; i++) step();
    if (m_busy || exp_q.size() != 0) fail_now("drain");
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
